// File: rtl/dm_responder.sv
// Word-organised data memory serving one byte/halfword/word load or store per request.
// Sub-word stores are read-modify-write; misaligned accesses complete with err and no write.
module dm_responder #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  siz,
    input  logic        SE_s,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t              state, state_nxt;
    logic                we_q;
    logic [1:0]          siz_q;
    logic                se_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         buf_q;
    logic [31:0]         mem [DEPTH];
    logic [ADDR_W-3:0]   idx;
    logic [31:0]         rd_word;
    logic [31:0]         merged;
    logic                mis;
    logic                unused_addr_hi;

    // Upper address bits alias onto the implemented range.
    assign unused_addr_hi = ^addr[31:ADDR_W];

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                                 input logic [1:0] a, input logic se);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   return se ? 32'(b) : {24'b0, b};
            2'b01:   return se ? 32'(h) : {16'b0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] a);
        logic [31:0] m;
        m = w;
        case (sz)
            2'b00:   m[{a, 3'b000} +: 8] = wd[7:0];
            2'b01:   m[{a[1], 4'b0000} +: 16] = wd[15:0];
            default: m = wd;
        endcase
        return m;
    endfunction

    assign idx     = addr_q[ADDR_W-1:2];
    assign rd_word = mem[idx];
    assign mis     = misaligned(siz_q, addr_q[1:0]);
    assign merged  = store_merge(buf_q, wdata_q, siz_q, addr_q[1:0]);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = RD;
            RD:      state_nxt = (we_q && !mis) ? WR : RESP;
            WR:      state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        ack   = (state == RESP);
    end

    // Request capture and read buffer.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            we_q    <= 1'b0;
            siz_q   <= 2'b00;
            se_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
        end else begin
            if (state == IDLE && req) begin
                we_q    <= we;
                siz_q   <= siz;
                se_q    <= SE_s;
                addr_q  <= addr[ADDR_W-1:0];
                wdata_q <= wdata;
            end
            if (state == RD) buf_q <= rd_word;
        end
    end

    // Storage: single write port, used only in WR.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == WR) begin
            mem[idx] <= merged;
        end
    end

    // Response registers load on the edge entering RESP and hold until the next one.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rdata <= '0;
            err   <= 1'b0;
        end else if (state == RD && (!we_q || mis)) begin
            rdata <= mis ? 32'h0 : load_extract(rd_word, siz_q, addr_q[1:0], se_q);
            err   <= mis;
        end else if (state == WR) begin
            rdata <= merged;
            err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: table of accesses with hand-computed results,
// plus reset-abort and held-req sequences.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        rst_;
    logic        req;
    logic        we;
    logic [1:0]  siz;
    logic        SE_s;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    dm_responder #(.ADDR_W(8)) dut (
        .clk(clk), .rst_(rst_), .req(req), .we(we), .siz(siz), .SE_s(SE_s),
        .addr(addr), .wdata(wdata), .ready(ready), .ack(ack), .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  siz;
        logic        se;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    // Issue one request; latency is the number of clock edges from acceptance
    // (inclusive of the acceptance cycle) until ack is observed.
    task automatic access(input logic w, input logic [1:0] s, input logic se,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        check("ready_before_req", {31'b0, ready}, 32'h1);
        req = 1'b1; we = w; siz = s; SE_s = se; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0;
        rd = 'x;
        er = 1'bx;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            lat++;
            if (ack) begin
                rd = rdata;
                er = err;
                break;
            end
        end
        if (!ack) begin
            n_checks++;
            $display("FAIL ack_timeout: no ack after %0d cycles, expected one", lat);
            lat = -1;
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          accepts;
        int          acks;

        vecs = '{
            '{1'b1, 2'b10, 1'b0, 32'h10,  32'h8765_4321, 32'h8765_4321, 1'b0, 3},
            '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,         32'h8765_4321, 1'b0, 2},
            '{1'b0, 2'b00, 1'b1, 32'h11,  32'h0,         32'h0000_0043, 1'b0, 2},
            '{1'b0, 2'b00, 1'b1, 32'h13,  32'h0,         32'hFFFF_FF87, 1'b0, 2},
            '{1'b0, 2'b00, 1'b0, 32'h13,  32'h0,         32'h0000_0087, 1'b0, 2},
            '{1'b0, 2'b01, 1'b1, 32'h12,  32'h0,         32'hFFFF_8765, 1'b0, 2},
            '{1'b0, 2'b01, 1'b0, 32'h12,  32'h0,         32'h0000_8765, 1'b0, 2},
            '{1'b1, 2'b00, 1'b0, 32'h12,  32'h1234_56AB, 32'h87AB_4321, 1'b0, 3},
            '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,         32'h87AB_4321, 1'b0, 2},
            '{1'b1, 2'b01, 1'b0, 32'h10,  32'h5555_CAFE, 32'h87AB_CAFE, 1'b0, 3},
            '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,         32'h87AB_CAFE, 1'b0, 2},
            '{1'b1, 2'b01, 1'b0, 32'h11,  32'h0000_FFFF, 32'h0000_0000, 1'b1, 2},
            '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,         32'h87AB_CAFE, 1'b0, 2},
            '{1'b0, 2'b10, 1'b0, 32'h110, 32'h0,         32'h87AB_CAFE, 1'b0, 2},
            '{1'b0, 2'b10, 1'b0, 32'h12,  32'h0,         32'h0000_0000, 1'b1, 2},
            '{1'b0, 2'b11, 1'b0, 32'h10,  32'h0,         32'h87AB_CAFE, 1'b0, 2},
            '{1'b0, 2'b00, 1'b1, 32'h10,  32'h0,         32'hFFFF_FFFE, 1'b0, 2},
            '{1'b0, 2'b00, 1'b1, 32'h11,  32'h0,         32'hFFFF_FFCA, 1'b0, 2},
            '{1'b0, 2'b01, 1'b0, 32'h10,  32'h0,         32'h0000_CAFE, 1'b0, 2},
            '{1'b0, 2'b01, 1'b1, 32'h13,  32'h0,         32'h0000_0000, 1'b1, 2}
        };

        rst_ = 1'b0; req = 1'b0; we = 1'b0; siz = 2'b00; SE_s = 1'b0;
        addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", {31'b0, ready}, 32'h1);
        check("reset_ack",   {31'b0, ack},   32'h0);
        check("reset_rdata", rdata,          32'h0);
        check("reset_err",   {31'b0, err},   32'h0);
        rst_ = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            access(vecs[i].we, vecs[i].siz, vecs[i].se, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
        end

        // Reset during RD of a store: no ack, storage cleared, write never commits.
        access(1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAA_5555, rd, er, lat);
        check("pre_abort_store", rd, 32'hAAAA_5555);
        @(negedge clk);
        req = 1'b1; we = 1'b1; siz = 2'b10; SE_s = 1'b0; addr = 32'h20; wdata = 32'h1234_5678;
        @(posedge clk);
        #1 req = 1'b0;
        rst_ = 1'b0;
        #1;
        check("abort_ready", {31'b0, ready}, 32'h1);
        check("abort_ack",   {31'b0, ack},   32'h0);
        check("abort_rdata", rdata,          32'h0);
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack) acks++;
        end
        rst_ = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ack) acks++;
        end
        check("abort_no_ack", acks, 0);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
        check("abort_load_20", rd, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        check("abort_load_10", rd, 32'h0);

        // req held high: exactly one ack per acceptance.
        access(1'b1, 2'b10, 1'b0, 32'h30, 32'hC0DE_F00D, rd, er, lat);
        accepts = 0;
        acks = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; siz = 2'b10; SE_s = 1'b0; addr = 32'h30;
        for (int c = 0; c < 10; c++) begin
            if (ready && req) accepts++;
            if (ack) begin
                acks++;
                check($sformatf("held_rdata_%0d", acks), rdata, 32'hC0DE_F00D);
            end
            @(negedge clk);
        end
        req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (ack) begin
                acks++;
                check($sformatf("held_rdata_%0d", acks), rdata, 32'hC0DE_F00D);
            end
            @(negedge clk);
        end
        check("held_acks_eq_accepts", acks, accepts);
        check("held_accepts", accepts, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
